// File: rtl/acia_pkg.sv
// Shared types and register map for the ACIA transmit-only serial port.
package acia_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Register offsets inside the 4-byte window; offset 3 is reserved.
  localparam logic [1:0] ACIA_DATA   = 2'd0;
  localparam logic [1:0] ACIA_STATUS = 2'd1;
  localparam logic [1:0] ACIA_CTRL   = 2'd2;

  localparam int unsigned DATA_BITS = 8;

  typedef struct packed {
    logic       busy;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [3:0] zero;
  } acia_status_t;

  typedef struct packed {
    logic irq_enable;
    logic tx_enable;
  } acia_ctrl_t;

endpackage

// File: rtl/acia_fifo.sv
// Transmit FIFO: power-of-two depth, wrapping pointers, push accepted while
// full only when a pop happens in the same cycle.
module acia_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/acia_tx.sv
// Memory-mapped 8N1 serial transmitter for the cpu6502 bus: DATA/STATUS/CTRL
// registers, transmit FIFO, registered tx line and level interrupt.
module acia_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'h8000,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address_in,
  input  logic [7:0]  data_in,
  input  logic        READ_write,
  output logic [7:0]  data_out,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  import acia_pkg::*;

  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  // Bus decode
  logic [15:0] offset;
  logic [1:0]  reg_sel;
  logic        wr_data;
  logic        wr_status;
  logic        wr_ctrl;

  assign offset    = address_in - BASE_ADDR;
  assign hit       = (offset[15:2] == 14'd0);
  assign reg_sel   = offset[1:0];
  assign wr_data   = hit & READ_write & (reg_sel == ACIA_DATA);
  assign wr_status = hit & READ_write & (reg_sel == ACIA_STATUS);
  assign wr_ctrl   = hit & READ_write & (reg_sel == ACIA_CTRL);

  // Registers and FIFO
  acia_ctrl_t   ctrl_q;
  acia_ctrl_t   ctrl_d;
  logic         overflow_q;
  logic         overflow_d;
  acia_status_t status;

  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_has_data;

  // Transmitter state
  tx_state_t   state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        baud_done;
  logic        busy;

  acia_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .wdata (data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fifo_has_data = (fifo_count != '0);
  assign baud_done     = (baud_q == BAUD_LAST);
  assign busy          = (state_q != IDLE);

  // A new byte is taken either from idle or on the last clock of STOP, which
  // is what makes consecutive frames abut with no idle gap.
  assign fifo_pop = ctrl_q.tx_enable & fifo_has_data &
                    ((state_q == IDLE) | ((state_q == STOP) & baud_done));

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    ctrl_d     = ctrl_q;
    overflow_d = overflow_q;
    if (wr_ctrl) ctrl_d = acia_ctrl_t'(data_in[1:0]);
    if (wr_status) begin
      overflow_d = 1'b0;
    end else if (wr_data & fifo_full & ~fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      overflow_q <= overflow_d;
    end
  end

  assign status = {busy, fifo_full, fifo_empty, overflow_q, 4'b0000};

  always_comb begin
    data_out = 8'h00;
    if (hit) begin
      case (reg_sel)
        ACIA_STATUS: data_out = status;
        ACIA_CTRL:   data_out = {6'b000000, ctrl_q};
        default:     data_out = 8'h00;
      endcase
    end
  end

  assign irq = ctrl_q.irq_enable & fifo_empty & ~busy;

  // tx_q always holds the level of the bit currently on the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (fifo_pop) begin
            state_q <= START;
            shift_q <= fifo_rdata;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state_q <= DATA;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (fifo_pop) begin
              state_q <= START;
              shift_q <= fifo_rdata;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
      endcase
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_acia_tx.sv
// Bench for acia_tx: frame-level reference model checked every cycle, a serial
// line decoder, directed register/timing scenarios and a randomized bus phase.
module tb_acia_tx;

  localparam int          CLK_DIV = 4;
  localparam int          DEPTH   = 4;
  localparam int          FRAME   = 10 * CLK_DIV;
  localparam logic [15:0] BASE    = 16'h8000;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic [15:0] address_in = 16'h0000;
  logic [7:0]  data_in    = 8'h00;
  logic        READ_write = 1'b0;
  logic [7:0]  data_out;
  logic        hit;
  logic        tx;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  acia_tx #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address_in (address_in),
    .data_in    (data_in),
    .READ_write (READ_write),
    .data_out   (data_out),
    .hit        (hit),
    .tx         (tx),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue, clocks left in the current frame, frame bits.
  logic [7:0] q_m[$];
  logic [7:0] exp_sent[$];
  logic [7:0] rx_q[$];
  int         frame_left = 0;
  logic [9:0] frame_m    = 10'h3FF;
  logic       ovf_m      = 1'b0;
  logic [1:0] ctrl_m     = 2'b00;
  logic       m_pop;
  logic [7:0] m_cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic in_window(input logic [15:0] a);
    return (a >= BASE) && (a <= BASE + 16'd3);
  endfunction

  function automatic logic exp_tx();
    if (frame_left == 0) return 1'b1;
    return frame_m[(FRAME - frame_left) / CLK_DIV];
  endfunction

  function automatic logic [7:0] exp_status();
    return {frame_left != 0, q_m.size() == DEPTH, q_m.size() == 0, ovf_m, 4'b0000};
  endfunction

  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    if (!in_window(a)) return 8'h00;
    case (a - BASE)
      16'd1:   return exp_status();
      16'd2:   return {6'b000000, ctrl_m};
      default: return 8'h00;
    endcase
  endfunction

  // Model update on every rising edge (inputs are stable since posedge+1).
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      q_m.delete();
      frame_left = 0;
      frame_m    = 10'h3FF;
      ovf_m      = 1'b0;
      ctrl_m     = 2'b00;
    end else begin
      m_pop = ctrl_m[0] && (q_m.size() > 0) && (frame_left <= 1);
      if (m_pop) begin
        m_cur      = q_m.pop_front();
        frame_m    = {1'b1, m_cur, 1'b0};
        frame_left = FRAME;
        exp_sent.push_back(m_cur);
      end else if (frame_left > 0) begin
        frame_left--;
      end
      if (READ_write && in_window(address_in)) begin
        case (address_in - BASE)
          16'd0: if (q_m.size() < DEPTH) q_m.push_back(data_in); else ovf_m = 1'b1;
          16'd1: ovf_m = 1'b0;
          16'd2: ctrl_m = data_in[1:0];
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("rst_tx", tx, 1);
      check("rst_irq", irq, 0);
    end else begin
      check("tx", tx, exp_tx());
      check("irq", irq, (ctrl_m[1] && q_m.size() == 0 && frame_left == 0));
      check("hit", hit, in_window(address_in));
      check("data_out", data_out, exp_rd(address_in));
    end
  end

  // Serial line decoder: samples mid-bit, pushes each received byte.
  int         rx_pos = 0;
  int         rx_bit;
  logic [7:0] rx_byte;
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      rx_pos = 0;
    end else if (rx_pos == 0) begin
      if (tx === 1'b0) rx_pos = 1;
    end else begin
      if (rx_pos % CLK_DIV == CLK_DIV / 2) begin
        rx_bit = rx_pos / CLK_DIV;
        if (rx_bit == 0) check("rx_start_bit", tx, 0);
        else if (rx_bit <= 8) rx_byte[rx_bit-1] = tx;
        else begin
          check("rx_stop_bit", tx, 1);
          rx_q.push_back(rx_byte);
        end
      end
      rx_pos = (rx_pos == FRAME - 1) ? 0 : rx_pos + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    address_in = a;
    data_in    = d;
    READ_write = 1'b1;
    @(posedge clk);
    #1;
    READ_write = 1'b0;
    address_in = 16'h0000;
    data_in    = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    address_in = a;
    READ_write = 1'b0;
    #1;
    d = data_out;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("reset_tx_immediate", tx, 1);
    idle(2);
    reset = 1'b1;
    rx_q.delete();
    exp_sent.delete();
  endtask

  task automatic drain_and_compare(input string tag);
    int budget;
    budget = 0;
    while ((frame_left != 0 || q_m.size() != 0) && budget < 3000) begin
      idle(1);
      budget++;
    end
    check({tag, "_drain_in_time"}, budget < 3000, 1);
    idle(3);
    check({tag, "_rx_count"}, rx_q.size(), exp_sent.size());
    for (int i = 0; i < exp_sent.size() && i < rx_q.size(); i++)
      check({tag, "_rx_byte"}, rx_q[i], exp_sent[i]);
  endtask

  logic [7:0]  rd;
  logic [0:9]  pat55  = 10'b0_10101010_1;
  logic [0:19] pat_bb = 20'b0_10100101_1_0_00111100_1;
  logic [7:0]  exp5 [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  int          r;

  initial begin
    // Reset state
    do_reset();
    bus_read(16'h0000, rd);
    check("unmapped_hit", hit, 0);
    check("unmapped_data", rd, 8'h00);
    check("reset_irq", irq, 0);
    check("reset_tx", tx, 1);
    bus_read(BASE + 16'd1, rd);
    check("reset_status", rd, 8'h20);
    idle(1);

    // Single 0x55 frame, bit-by-bit against a literal waveform
    bus_write(BASE + 16'd2, 8'h01);
    bus_write(BASE, 8'h55);
    address_in = BASE + 16'd1;
    idle(1);
    for (int i = 0; i < FRAME; i++) begin
      check("f55_tx", tx, pat55[i / CLK_DIV]);
      check("f55_busy", data_out[7], 1);
      idle(1);
    end
    check("f55_status_after", data_out, 8'h20);
    check("f55_rx_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) check("f55_rx_byte", rx_q[0], 8'h55);

    // Overflow: 5 writes with transmitter disabled, then clear
    do_reset();
    for (int i = 1; i <= 5; i++) bus_write(BASE, 8'(8'h11 * i));
    bus_read(BASE + 16'd1, rd);
    check("ovf_status", rd, 8'h50);
    bus_write(BASE + 16'd1, 8'hFF);
    bus_read(BASE + 16'd1, rd);
    check("ovf_cleared", rd, 8'h40);
    bus_write(BASE + 16'd2, 8'h01);
    drain_and_compare("ovf");
    check("ovf_rx_count_lit", rx_q.size(), 4);
    if (rx_q.size() == 4) check("ovf_last_byte", rx_q[3], 8'h44);

    // Back-to-back frames A5, 3C
    do_reset();
    bus_write(BASE, 8'hA5);
    bus_write(BASE, 8'h3C);
    bus_write(BASE + 16'd2, 8'h01);
    address_in = BASE + 16'd1;
    idle(1);
    for (int i = 0; i < 2 * FRAME; i++) begin
      check("b2b_tx", tx, pat_bb[i / CLK_DIV]);
      check("b2b_busy", data_out[7], 1);
      idle(1);
    end
    check("b2b_idle_after", data_out[7], 0);
    drain_and_compare("b2b");

    // Push on the pop edge of a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) bus_write(BASE, exp5[i]);
    bus_read(BASE + 16'd1, rd);
    check("full_status", rd, 8'h40);
    bus_write(BASE + 16'd2, 8'h01);
    bus_write(BASE, exp5[4]);
    bus_read(BASE + 16'd1, rd);
    check("popedge_status", rd, 8'hC0);
    drain_and_compare("popedge");
    check("popedge_rx_count_lit", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) check("popedge_rx_lit", rx_q[i], exp5[i]);

    // Reset in the middle of a frame
    do_reset();
    bus_write(BASE, 8'h00);
    bus_write(BASE, 8'h77);
    bus_write(BASE + 16'd2, 8'h01);
    idle(1);
    idle(16);
    check("midframe_tx_before_reset", tx, 0);
    do_reset();
    bus_read(BASE + 16'd1, rd);
    check("midframe_status_after", rd, 8'h20);
    idle(60);
    check("midframe_line_idle", tx, 1);
    check("midframe_no_rx", rx_q.size(), 0);

    // Interrupt timing and window edges
    do_reset();
    bus_write(BASE, 8'h5A);
    bus_write(BASE + 16'd2, 8'h03);
    check("irq_low_queued", irq, 0);
    idle(1);
    for (int i = 0; i < FRAME; i++) begin
      check("irq_low_in_frame", irq, 0);
      idle(1);
    end
    check("irq_after_stop", irq, 1);
    bus_read(16'h8004, rd);
    check("hit_8004", hit, 0);
    check("data_8004", rd, 8'h00);
    bus_read(16'h8003, rd);
    check("hit_8003", hit, 1);
    check("data_8003", rd, 8'h00);
    bus_read(16'h7FFF, rd);
    check("hit_7fff", hit, 0);
    idle(1);

    // Randomized bus traffic, checked by the per-cycle model and decoder
    do_reset();
    for (int it = 0; it < 2000; it++) begin
      r = $urandom_range(0, 15);
      if (r < 3) begin
        bus_write(BASE, 8'($urandom));
      end else if (r == 3) begin
        bus_write(BASE + 16'd2, {6'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0)});
      end else if (r == 4) begin
        bus_write(BASE + 16'd1, 8'($urandom));
      end else if (r == 5) begin
        bus_write(16'(BASE - 16'd2 + 16'($urandom_range(0, 7))), 8'($urandom));
      end else begin
        address_in = 16'(BASE - 16'd2 + 16'($urandom_range(0, 7)));
        idle($urandom_range(1, 12));
      end
    end
    bus_write(BASE + 16'd2, 8'h01);
    drain_and_compare("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
